// File: rtl/ps2_pkg.sv
// Shared types and helpers for the PS/2 receiver: FSM state encoding,
// frame bit counts and the odd-parity check.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_t;

  localparam int DATA_BITS  = 8;
  localparam int FRAME_BITS = 11;

  // True when data plus parity carry an odd number of ones.
  function automatic logic odd_parity(input logic [7:0] data, input logic parity);
    return ^{data, parity};
  endfunction

endpackage

// File: rtl/ps2_sync_fifo.sv
// First-word fall-through byte FIFO with ADDR_W+1 bit wrapping pointers;
// full and empty come straight from the pointer compare.
module ps2_sync_fifo #(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [7:0]        push_data,
  input  logic              pop,
  output logic [7:0]        head,
  output logic              valid,
  output logic              full,
  output logic [ADDR_W:0]   count
);

  logic [7:0]      mem [DEPTH];
  logic [ADDR_W:0] wr_ptr;
  logic [ADDR_W:0] rd_ptr;
  logic            empty;
  logic            pop_ok;
  logic            push_ok;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                 (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
  assign count = wr_ptr - rd_ptr;
  assign valid = !empty;

  // pop is honoured only while valid; push is honoured when not full or
  // when a pop frees the head slot in the same cycle.
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  assign head = empty ? 8'h00 : mem[rd_ptr[ADDR_W-1:0]];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr[ADDR_W-1:0]] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 keyboard receiver: synchroniser, glitch filter, frame FSM and byte FIFO.
// Optional idle-frame timeout is built when PS2_RX_TIMEOUT_EN is defined.
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH          = 32,
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 100000,
  localparam int ADDR_W        = $clog2(DEPTH)
) (
  input  logic              system_clk,
  input  logic              reset,
  input  logic              PS2_clk,
  input  logic              PS2_data,
  input  logic              read,
  input  logic              clr_ovf,
  output logic [7:0]        out,
  output logic              valid,
  output logic              full,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              frame_err
);

  if (DEPTH < 2 || DEPTH > 256 || (DEPTH & (DEPTH - 1)) != 0 ||
      FILTER_LEN < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("ps2_rx_fifo: illegal parameter combination");
  end

  localparam int FW = $clog2(FILTER_LEN + 1);

  // Index 1 carries the PS/2 clock, index 0 the PS/2 data line.
  logic [1:0]    sync1;
  logic [1:0]    sync2;
  logic [1:0]    filt;
  logic [FW-1:0] fcnt [2];
  logic          clk_prev;
  logic          fall;
  logic          bit_in;

  always_ff @(posedge system_clk or posedge reset) begin
    if (reset) begin
      sync1    <= 2'b11;
      sync2    <= 2'b11;
      filt     <= 2'b11;
      clk_prev <= 1'b1;
      for (int i = 0; i < 2; i++) fcnt[i] <= '0;
    end else begin
      sync1    <= {PS2_clk, PS2_data};
      sync2    <= sync1;
      clk_prev <= filt[1];
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == filt[i]) begin
          fcnt[i] <= '0;
        end else if (fcnt[i] == FW'(FILTER_LEN - 1)) begin
          filt[i] <= sync2[i];
          fcnt[i] <= '0;
        end else begin
          fcnt[i] <= fcnt[i] + 1'b1;
        end
      end
    end
  end

  assign fall   = clk_prev && !filt[1];
  assign bit_in = filt[0];

  ps2_state_t state;
  ps2_state_t state_next;
  logic [2:0] bit_cnt;
  logic [2:0] bit_cnt_next;
  logic [7:0] shift;
  logic [7:0] shift_next;
  logic       par_bit;
  logic       par_bit_next;
  logic       frame_done;
  logic       frame_good;
  logic       timeout;
  logic       wr_pend;
  logic [7:0] wr_byte;
  logic       ovf_evt;

`ifdef PS2_RX_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt;

  always_ff @(posedge system_clk or posedge reset) begin
    if (reset) begin
      to_cnt <= '0;
    end else if (state == IDLE || fall || timeout) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  assign timeout = (state != IDLE) && !fall && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_next   = state;
    bit_cnt_next = bit_cnt;
    shift_next   = shift;
    par_bit_next = par_bit;
    frame_done   = 1'b0;
    frame_good   = 1'b0;
    if (timeout) begin
      state_next = IDLE;
    end else if (fall) begin
      unique case (state)
        IDLE: begin
          if (!bit_in) begin
            state_next   = DATA;
            bit_cnt_next = '0;
          end
        end
        DATA: begin
          shift_next   = {bit_in, shift[7:1]};
          bit_cnt_next = bit_cnt + 1'b1;
          if (bit_cnt == 3'(DATA_BITS - 1)) state_next = PARITY;
        end
        PARITY: begin
          par_bit_next = bit_in;
          state_next   = STOP;
        end
        STOP: begin
          frame_done = 1'b1;
          frame_good = bit_in && odd_parity(shift, par_bit);
          state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge system_clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shift     <= '0;
      par_bit   <= 1'b0;
      wr_pend   <= 1'b0;
      wr_byte   <= '0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_next;
      bit_cnt   <= bit_cnt_next;
      shift     <= shift_next;
      par_bit   <= par_bit_next;
      wr_pend   <= frame_done && frame_good;
      frame_err <= (frame_done && !frame_good) || timeout;
      if (frame_done) wr_byte <= shift;
    end
  end

  // A set request in the same cycle as clr_ovf keeps the flag high.
  assign ovf_evt = wr_pend && full && !(read && valid);

  always_ff @(posedge system_clk or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (ovf_evt) begin
      overflow <= 1'b1;
    end else if (clr_ovf) begin
      overflow <= 1'b0;
    end
  end

  ps2_sync_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk       (system_clk),
    .rst       (reset),
    .push      (wr_pend),
    .push_data (wr_byte),
    .pop       (read),
    .head      (out),
    .valid     (valid),
    .full      (full),
    .count     (count)
  );

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Self-checking bench for ps2_rx_fifo: table of frames plus hand-written
// overflow, glitch, mid-frame reset and stalled-frame sequences.
module tb_ps2_rx_fifo;
  import ps2_pkg::*;

  localparam int DEPTH      = 4;
  localparam int FILTER_LEN = 4;
  localparam int TIMEOUT    = 300;
  localparam int HALF       = 12;

  logic       clk = 1'b0;
  logic       rst;
  logic       ps2_clk;
  logic       ps2_data;
  logic       read;
  logic       clr_ovf;
  logic [7:0] out_byte;
  logic       valid;
  logic       full;
  logic [2:0] count;
  logic       overflow;
  logic       frame_err;

  ps2_rx_fifo #(
    .DEPTH          (DEPTH),
    .FILTER_LEN     (FILTER_LEN),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .system_clk (clk),
    .reset      (rst),
    .PS2_clk    (ps2_clk),
    .PS2_data   (ps2_data),
    .read       (read),
    .clr_ovf    (clr_ovf),
    .out        (out_byte),
    .valid      (valid),
    .full       (full),
    .count      (count),
    .overflow   (overflow),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int err_seen = 0;
  int model_cnt = 0;
  logic model_ovf = 1'b0;
  logic [7:0] exp_q[$];

  always @(negedge clk) if (frame_err) err_seen++;

  typedef struct {
    logic [7:0] data;
    logic       bad_par;
    logic       stop;
    int         exp_count;
    int         exp_err;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    ps2_data = b;
    wait_cyc(HALF / 2);
    ps2_clk = 1'b0;
    wait_cyc(HALF);
    ps2_clk = 1'b1;
    wait_cyc(HALF / 2);
  endtask

  // Drives one frame and updates the scoreboard for good frames.
  task automatic send_frame(input logic [7:0] d, input logic bad_par, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit((~^d) ^ bad_par);
    send_bit(stop);
    ps2_data = 1'b1;
    wait_cyc(4);
    if (!bad_par && stop) begin
      if (model_cnt < DEPTH) begin
        exp_q.push_back(d);
        model_cnt++;
      end else begin
        model_ovf = 1'b1;
      end
    end
  endtask

  task automatic pop_check();
    logic [7:0] e;
    e = exp_q.pop_front();
    check("pop_valid", valid, 1);
    check("pop_data", out_byte, e);
    read = 1'b1;
    wait_cyc(1);
    read = 1'b0;
    model_cnt--;
    wait_cyc(1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    wait_cyc(3);
    rst = 1'b0;
    exp_q.delete();
    model_cnt = 0;
    model_ovf = 1'b0;
    wait_cyc(3);
  endtask

  initial begin
    int e0;
    rst = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1; read = 1'b0; clr_ovf = 1'b0;

    vecs[0] = '{8'h1C, 1'b0, 1'b1, 1, 0};
    vecs[1] = '{8'hF0, 1'b1, 1'b1, 1, 1};
    vecs[2] = '{8'hA5, 1'b0, 1'b0, 1, 1};
    vecs[3] = '{8'h3C, 1'b0, 1'b1, 2, 0};
    vecs[4] = '{8'h00, 1'b0, 1'b1, 3, 0};
    vecs[5] = '{8'hFF, 1'b1, 1'b1, 3, 1};

    wait_cyc(2);
    check("rst_out", out_byte, 8'h00);
    check("rst_valid", valid, 0);
    check("rst_full", full, 0);
    check("rst_count", count, 0);
    check("rst_overflow", overflow, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_state", dut.state, IDLE);
    do_reset();

    read = 1'b1;
    wait_cyc(1);
    read = 1'b0;
    wait_cyc(1);
    check("empty_read_count", count, 0);

    for (int i = 0; i < 6; i++) begin
      e0 = err_seen;
      send_frame(vecs[i].data, vecs[i].bad_par, vecs[i].stop);
      check("vec_count", count, vecs[i].exp_count);
      check("vec_err", err_seen - e0, vecs[i].exp_err);
      check("vec_head", out_byte, 8'h1C);
    end
    while (exp_q.size() > 0) pop_check();
    check("drain_valid", valid, 0);
    check("drain_out", out_byte, 8'h00);

    e0 = err_seen;
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b0, 1'b1);
    check("ovf_count", count, 4);
    check("ovf_full", full, 1);
    check("ovf_flag", overflow, model_ovf);
    check("ovf_no_err", err_seen - e0, 0);
    clr_ovf = 1'b1;
    wait_cyc(1);
    clr_ovf = 1'b0;
    check("ovf_cleared", overflow, 0);
    while (exp_q.size() > 0) pop_check();
    check("ovf_drain_full", full, 0);

    e0 = err_seen;
    ps2_data = 1'b0;
    wait_cyc(4);
    ps2_clk = 1'b0;
    wait_cyc(2);
    ps2_clk = 1'b1;
    wait_cyc(4);
    ps2_data = 1'b1;
    wait_cyc(20);
    check("glitch_state", dut.state, IDLE);
    send_frame(8'h77, 1'b0, 1'b1);
    check("glitch_count", count, 1);
    check("glitch_err", err_seen - e0, 0);
    check("glitch_head", out_byte, 8'h77);

    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    e0 = err_seen;
    do_reset();
    check("midrst_out", out_byte, 8'h00);
    check("midrst_valid", valid, 0);
    check("midrst_count", count, 0);
    check("midrst_state", dut.state, IDLE);
    send_frame(8'h5A, 1'b0, 1'b1);
    check("midrst_new_count", count, 1);
    check("midrst_err", err_seen - e0, 0);
    pop_check();

    e0 = err_seen;
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    wait_cyc(TIMEOUT + 50);
`ifdef PS2_RX_TIMEOUT_EN
    check("timeout_err", err_seen - e0, 1);
    check("timeout_state", dut.state, IDLE);
    send_frame(8'h29, 1'b0, 1'b1);
    check("timeout_next_count", count, 1);
    pop_check();
`else
    check("stall_no_err", err_seen - e0, 0);
    check("stall_state", dut.state, DATA);
    do_reset();
    send_frame(8'h29, 1'b0, 1'b1);
    check("stall_next_count", count, 1);
    pop_check();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
